// File: rtl/hb_decim2_nch_if.sv
// Sample-stream bundle for the half-band decimator: per-channel packed data plus shared strobes.
interface hb_decim2_nch_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 10,
    parameter int NCH   = 2
);
    // Valid-only stream, no ready: a sample is taken on every clock where in_valid=1,
    // and out_valid/sat are one-cycle pulses qualifying out_data, which otherwise holds.
    logic                  in_valid;
    logic [NCH*IN_W-1:0]   in_data;
    logic                  bypass;
    logic                  out_valid;
    logic [NCH*OUT_W-1:0]  out_data;
    logic                  sat;
    logic                  dbg_phase;

    modport master (
        output in_valid, in_data, bypass,
        input  out_valid, out_data, sat, dbg_phase
    );

    modport slave (
        input  in_valid, in_data, bypass,
        output out_valid, out_data, sat, dbg_phase
    );
endinterface

// File: rtl/hb_decim2_nch.sv
// 19-tap half-band decimate-by-2 filter over NCH lock-stepped channels.
// The filter path has a two-register pipeline; the bypass path has a one-register pipeline.
module hb_decim2_nch #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 10,
    parameter int NCH   = 2,
    parameter int C0    = 1,
    parameter int C1    = -4,
    parameter int C2    = 13,
    parameter int C3    = -40,
    parameter int C4    = 158,
    parameter int CC    = 256,
    parameter int SHIFT = 9,
    parameter int ACC_W = IN_W + 10
) (
    input  logic           clk,
    input  logic           rst_n,
    hb_decim2_nch_if.slave io
);
    localparam int DL_N = 18;

    localparam logic signed [ACC_W-1:0] K0    = ACC_W'(C0);
    localparam logic signed [ACC_W-1:0] K1    = ACC_W'(C1);
    localparam logic signed [ACC_W-1:0] K2    = ACC_W'(C2);
    localparam logic signed [ACC_W-1:0] K3    = ACC_W'(C3);
    localparam logic signed [ACC_W-1:0] K4    = ACC_W'(C4);
    localparam logic signed [ACC_W-1:0] KC    = ACC_W'(CC);
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W-1:0]  dl_q [NCH][DL_N];
    logic signed [IN_W-1:0]  dl_d [NCH][DL_N];
    logic                    phase_q, phase_d;
    logic                    v1_q, v1_d;
    logic signed [ACC_W-1:0] acc_q [NCH];
    logic signed [ACC_W-1:0] acc_d [NCH];
    logic signed [ACC_W-1:0] sum_c [NCH];
    logic signed [ACC_W-1:0] y_c;
    logic                    out_valid_q, out_valid_d;
    logic [NCH*OUT_W-1:0]    out_data_q, out_data_d;
    logic                    sat_q, sat_d;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [IN_W-1:0] v);
        return ACC_W'(v);
    endfunction

    // dl_q[ch][k] holds x[n-1-k]; bypass keeps the history and phase cleared.
    always_comb begin
        phase_d = phase_q;
        dl_d    = dl_q;
        if (io.bypass) begin
            phase_d = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < DL_N; k++) begin
                    dl_d[ch][k] = '0;
                end
            end
        end else if (io.in_valid) begin
            phase_d = ~phase_q;
            for (int ch = 0; ch < NCH; ch++) begin
                dl_d[ch][0] = $signed(io.in_data[ch*IN_W +: IN_W]);
                for (int k = 1; k < DL_N; k++) begin
                    dl_d[ch][k] = dl_q[ch][k-1];
                end
            end
        end
    end

    // Only even-index taps plus the centre are non-zero; symmetric pairs share one multiply.
    always_comb begin
        v1_d = io.in_valid & ~io.bypass & phase_q;
        for (int ch = 0; ch < NCH; ch++) begin
            sum_c[ch] = K0 * (sx($signed(io.in_data[ch*IN_W +: IN_W])) + sx(dl_q[ch][17]))
                      + K1 * (sx(dl_q[ch][1]) + sx(dl_q[ch][15]))
                      + K2 * (sx(dl_q[ch][3]) + sx(dl_q[ch][13]))
                      + K3 * (sx(dl_q[ch][5]) + sx(dl_q[ch][11]))
                      + K4 * (sx(dl_q[ch][7]) + sx(dl_q[ch][9]))
                      + KC * sx(dl_q[ch][8]);
            acc_d[ch] = v1_d ? sum_c[ch] : acc_q[ch];
        end
    end

    // A filter result already in the pipe takes the output slot ahead of a bypass sample.
    always_comb begin
        out_valid_d = 1'b0;
        sat_d       = 1'b0;
        out_data_d  = out_data_q;
        y_c         = '0;
        if (v1_q) begin
            out_valid_d = 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                y_c = (acc_q[ch] + RND) >>> SHIFT;
                if (y_c > Y_MAX) begin
                    y_c   = Y_MAX;
                    sat_d = 1'b1;
                end else if (y_c < Y_MIN) begin
                    y_c   = Y_MIN;
                    sat_d = 1'b1;
                end
                out_data_d[ch*OUT_W +: OUT_W] = y_c[OUT_W-1:0];
            end
        end else if (io.bypass && io.in_valid) begin
            out_valid_d = 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                out_data_d[ch*OUT_W +: OUT_W] = OUT_W'($signed(io.in_data[ch*IN_W +: IN_W]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                acc_q[ch] <= '0;
                for (int k = 0; k < DL_N; k++) begin
                    dl_q[ch][k] <= '0;
                end
            end
        end else begin
            phase_q     <= phase_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            acc_q       <= acc_d;
            dl_q        <= dl_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.sat       = sat_q;
    assign io.dbg_phase = phase_q;
endmodule

// File: tb/tb_hb_decim2_nch.sv
// Bench for hb_decim2_nch: a cycle-scheduled convolution model predicts every output slot.
module tb_hb_decim2_nch;
    localparam int IN_W  = 10;
    localparam int OUT_W = 10;
    localparam int NCH   = 2;
    localparam int SHIFT = 9;
    localparam int Y_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int Y_MIN = -(1 << (OUT_W - 1));

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hb_decim2_nch_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) bus ();

    hb_decim2_nch #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int edges        = 0;

    logic [NCH*OUT_W-1:0] exp_q[$];
    bit                   exp_sat_q[$];
    int                   exp_due_q[$];
    int                   hist[NCH][$];
    int                   phase = 0;
    logic [NCH*OUT_W-1:0] last_out = '0;
    bit                   capture = 1'b0;
    int                   cap_q[$];
    bit                   cap_sat_q[$];

    int h[19]       = '{1, 0, -4, 0, 13, 0, -40, 0, 158, 256, 158, 0, -40, 0, 13, 0, -4, 0, 1};
    int imp_ref[11] = '{1, -2, 7, -20, 79, 79, -20, 7, -2, 1, 0};

    function automatic int rnd_s();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int ch = 0; ch < NCH; ch++) hist[ch].delete();
        phase = 0;
    endtask

    // Predict the effect of the sample presented before the next edge.
    task automatic model(input bit v, input int d0, input int d1, input bit byp);
        int d[NCH];
        int acc;
        int y;
        bit s;
        logic [NCH*OUT_W-1:0] e;
        d[0] = d0;
        d[1] = d1;
        e = '0;
        s = 1'b0;
        if (byp) begin
            clear_model();
            if (v) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    y = d[ch];
                    e[ch*OUT_W +: OUT_W] = y[OUT_W-1:0];
                end
                exp_q.push_back(e);
                exp_sat_q.push_back(1'b0);
                exp_due_q.push_back(edges + 1);
            end
        end else if (v) begin
            for (int ch = 0; ch < NCH; ch++) begin
                hist[ch].push_front(d[ch]);
                if (hist[ch].size() > 19) void'(hist[ch].pop_back());
            end
            if (phase == 1) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    acc = 0;
                    for (int k = 0; k < hist[ch].size(); k++) acc += h[k] * hist[ch][k];
                    y = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
                    if (y > Y_MAX) begin y = Y_MAX; s = 1'b1; end
                    if (y < Y_MIN) begin y = Y_MIN; s = 1'b1; end
                    e[ch*OUT_W +: OUT_W] = y[OUT_W-1:0];
                end
                exp_q.push_back(e);
                exp_sat_q.push_back(s);
                exp_due_q.push_back(edges + 2);
            end
            phase = 1 - phase;
        end
    endtask

    task automatic check_cycle();
        logic [NCH*OUT_W-1:0] e;
        bit s;
        if (exp_due_q.size() > 0 && exp_due_q[0] == edges) begin
            e = exp_q.pop_front();
            s = exp_sat_q.pop_front();
            void'(exp_due_q.pop_front());
            chk("out_valid", 64'(bus.out_valid), 64'd1);
            chk("out_data", 64'(bus.out_data), 64'(e));
            chk("sat", 64'(bus.sat), 64'(s));
            last_out = e;
            if (capture) begin
                cap_q.push_back(int'($signed(bus.out_data[OUT_W-1:0])));
                cap_sat_q.push_back(bus.sat);
            end
        end else begin
            chk("idle_valid", 64'(bus.out_valid), 64'd0);
            chk("idle_sat", 64'(bus.sat), 64'd0);
            chk("hold_data", 64'(bus.out_data), 64'(last_out));
        end
    endtask

    task automatic step(input bit v, input int d0, input int d1, input bit byp);
        bus.in_valid = v;
        bus.in_data  = {IN_W'(d1), IN_W'(d0)};
        bus.bypass   = byp;
        model(v, d0, d1, byp);
        @(posedge clk);
        #1;
        edges++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, rnd_s(), rnd_s(), 1'b0);
    endtask

    task automatic clear_state();
        idle(3);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.bypass   = 1'b0;
        exp_q.delete();
        exp_sat_q.delete();
        exp_due_q.delete();
        clear_model();
        last_out = '0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_sat", 64'(bus.sat), 64'd0);
        repeat (n) begin
            @(posedge clk);
            #1;
            edges++;
            chk("rst_hold_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_hold_data", 64'(bus.out_data), 64'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_impulse(input bit gaps, input string tag);
        int g;
        clear_state();
        cap_q.delete();
        capture = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step(1'b1, (i == 1) ? 256 : 0, 0, 1'b0);
            if (gaps) begin
                g = int'($urandom_range(0, 5));
                repeat (g) step(1'b0, rnd_s(), rnd_s(), 1'b0);
            end
        end
        idle(3);
        capture = 1'b0;
        chk({tag, "_count"}, 64'(cap_q.size()), 64'd11);
        for (int i = 0; i < 11; i++) chk($sformatf("%s_%0d", tag, i), 64'(cap_q[i]), 64'(imp_ref[i]));
    endtask

    task automatic run_dc(input int v, input string tag);
        clear_state();
        cap_q.delete();
        capture = 1'b1;
        repeat (40) step(1'b1, v, v, 1'b0);
        idle(3);
        capture = 1'b0;
        chk({tag, "_count"}, 64'(cap_q.size()), 64'd20);
        for (int i = 9; i < 20; i++) chk($sformatf("%s_%0d", tag, i), 64'(cap_q[i]), 64'(v));
    endtask

    task automatic run_sat(input bit pos, input int exp_y, input string tag);
        int val;
        int k;
        clear_state();
        cap_q.delete();
        cap_sat_q.delete();
        capture = 1'b1;
        step(1'b1, 0, 0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            k = 19 - i;
            if (h[k] > 0)      val = pos ? 511 : -512;
            else if (h[k] < 0) val = pos ? -512 : 511;
            else               val = 0;
            step(1'b1, val, 0, 1'b0);
        end
        idle(3);
        capture = 1'b0;
        chk({tag, "_count"}, 64'(cap_q.size()), 64'd10);
        chk({tag, "_value"}, 64'(cap_q[9]), 64'(exp_y));
        if (pos) chk({tag, "_flag"}, 64'(cap_sat_q[9]), 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.bypass   = 1'b0;
        apply_reset(3);

        run_impulse(1'b0, "impulse");
        run_dc(100, "dc_pos");
        run_dc(-100, "dc_neg");
        run_sat(1'b1, 511, "sat_pos");
        run_sat(1'b0, -512, "sat_neg");
        run_impulse(1'b1, "impulse_gaps");

        // Bypass pass-through, then filtering from a clean history.
        idle(3);
        cap_q.delete();
        capture = 1'b1;
        step(1'b1, 5, rnd_s(), 1'b1);
        step(1'b1, -7, rnd_s(), 1'b1);
        step(1'b0, rnd_s(), rnd_s(), 1'b1);
        step(1'b1, 300, rnd_s(), 1'b1);
        step(1'b0, 0, 0, 1'b0);
        capture = 1'b0;
        chk("byp_count", 64'(cap_q.size()), 64'd3);
        chk("byp_0", 64'(cap_q[0]), 64'(5));
        chk("byp_1", 64'(cap_q[1]), 64'(-7));
        chk("byp_2", 64'(cap_q[2]), 64'(300));
        run_impulse(1'b0, "impulse_after_byp");

        // Reset lands between an odd sample and its output.
        clear_state();
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 256, 0, 1'b0);
        apply_reset(2);
        run_impulse(1'b0, "impulse_after_rst");

        // Random full-range traffic with gaps.
        clear_state();
        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, rnd_s(), rnd_s(), 1'b0);

        // Output in flight when bypass rises, random bypass burst, then random filtering again.
        clear_state();
        step(1'b1, rnd_s(), rnd_s(), 1'b0);
        step(1'b1, rnd_s(), rnd_s(), 1'b0);
        step(1'b0, rnd_s(), rnd_s(), 1'b1);
        for (int i = 0; i < 20; i++) step($urandom_range(0, 1) != 0, rnd_s(), rnd_s(), 1'b1);
        for (int i = 0; i < 100; i++) step($urandom_range(0, 3) != 0, rnd_s(), rnd_s(), 1'b0);

        idle(4);
        chk("exp_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/hb_decim2_nch.md
Name: hb_decim2_nch

Overview:
- Parametrised 19-tap half-band decimate-by-2 filter for the Rx decimation chain.
- Processes NCH time-aligned channels (default I/Q) with a shared valid strobe.
- Uses the half-band structure: a 10-tap symmetric odd branch plus a centre tap, with the zero taps skipped.
- Rounds, shifts and saturates the result to OUT_W.
- Adds valid handshaking, tolerance of input gaps, a bypass mode and a saturation indicator.

Parameters:
- IN_W, 10, input sample width per channel (signed).
- OUT_W, 10, output sample width per channel (signed); must be >= IN_W.
- NCH, 2, number of channels.
- C0, 1, outer tap coefficient (h[0], h[18]).
- C1, -4, coefficient for h[2], h[16].
- C2, 13, coefficient for h[4], h[14].
- C3, -40, coefficient for h[6], h[12].
- C4, 158, coefficient for h[8], h[10].
- CC, 256, centre tap h[9]; all other odd-index taps are 0.
- SHIFT, 9, output right shift (coefficient sum 512 gives unity DC gain).
- ACC_W, IN_W+10, internal accumulator width; no internal overflow is possible.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample strobe; one sample per channel per strobe.
- in_data  in  NCH*IN_W  channel k occupies bits [k*IN_W +: IN_W].
- bypass  in  1  1 = pass-through without decimation.
- out_valid  out  1  output strobe.
- out_data  out  NCH*OUT_W  channel k occupies bits [k*OUT_W +: OUT_W].
- sat  out  1  pulses with out_valid when any channel saturated on that output.

Behaviour:
- Reset: clk is the clock; rst_n is an asynchronous, active-low reset. While reset, out_valid=0, out_data=0, sat=0, phase=0, all delay lines and pipeline registers=0.
- Delay line: an 18-deep delay line per channel advances only on cycles with in_valid=1. Cycles with in_valid=0 hold all state, so arbitrary gaps between samples are allowed.
- Phase: phase toggles on each accepted sample. The sample accepted with phase=0 is "even"; the one accepted with phase=1 is "odd".
- Filter output: when an odd sample x[n] is accepted, the block computes acc = sum over k=0..18 of h[k]*x[n-k], with x[<0] = 0.
  - Symmetric pairs are pre-added before multiplication.
  - All arithmetic is full precision in ACC_W.
- Rounding and saturation:
  - y = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up).
  - y is then clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat=1 on that output if any channel clamped.
- Latency: out_valid pulses exactly 2 clk cycles after the in_valid cycle of the odd sample (input-to-accumulator register, then round/saturate register). Nothing is output on even samples.
- Output hold: out_data holds its last value between out_valid pulses. out_valid and sat are single-cycle pulses.
- Back-to-back input: in_valid held high every cycle gives one output every 2 cycles. There is no input backpressure; the block always accepts.
- Bypass = 1:
  - out_valid follows in_valid with 1-cycle latency.
  - out_data is in_data sign-extended to OUT_W; sat=0.
  - Delay lines and phase are held cleared.
  - An output already in flight when bypass rises is still delivered.
- Bypass falling edge: filtering restarts from zero history with phase=0.
- Channels: all channels share phase and timing; their data paths are fully independent.
- Reset mid-operation: all state clears immediately and any in-flight output is discarded. The first sample after reset release is even.

Test Plan:
- Impulse, ch0: bypass=0, in_valid continuous. ch0 gets 0 then 256, then zeros; ch1 all 0 -> ch0 outputs 1,-2,7,-20,79,79,-20,7,-2,1, then 0. ch1 stays 0. out_valid on every 2nd cycle, 2 cycles after each odd input. sat=0.
- DC: constant 100 on all channels -> output 100 from the 10th output onward. Repeat with -100 -> -100.
- Saturation: worst-case 19-sample pattern, 511 where h[k]>0 and -512 where h[k]<0 at odd-aligned time -> out=511 and sat=1 on that output. The inverted pattern -> -512 and sat=1.
- Gaps: impulse test repeated with random 0-5 cycle in_valid gaps -> identical output sequence. Each out_valid comes 2 cycles after the corresponding odd input.
- Bypass: bypass=1, inputs 5,-7,300 -> outputs 5,-7,300, 1 cycle after each input, sat=0. Then bypass=0 -> impulse test passes from clean state.
- Mid-run reset: assert rst_n=0 between an odd input and its output -> no out_valid, all outputs 0. After release, the impulse test passes.
